// File: rtl/serializer_8b10b_if.sv
// Byte handshake into the 8b/10b serializer: {k, data} qualified by valid/ready.
interface serializer_8b10b_if;
   logic [7:0] data;
   logic       k;
   logic       valid;
   logic       ready;

   modport master (output data, k, valid, input ready);
   modport slave  (input data, k, valid, output ready);
endinterface

// File: rtl/serializer_8b10b.sv
// 8b/10b transmit serializer: one-entry byte buffer, running-disparity encoder,
// MSB-first shifter, K28.5 idles whenever the buffer is empty.
module serializer_8b10b #(
   parameter int         WIDTH    = 10,
   parameter logic [8:0] IDLE_SYM = 9'h1BC
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   serializer_8b10b_if.slave         bus,
   output logic                      serialdata_o,
   output logic                      sob_o,
   output logic                      data_sent_o,
   output logic                      disp_o
);

   // Returns {dispout, dataout}; dataout[0] is code bit 'a', dataout[9] is 'j'.
   function automatic logic [10:0] encode_8b10b(input logic [8:0] sym, input logic dispin);
      logic [4:0] x;
      logic [2:0] y;
      logic       k;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       bal6, bal4, rd6, rd4, flip4, a7;
      logic [9:0] out;
      x = sym[4:0];
      y = sym[7:5];
      k = sym[8];
      case (x)
         5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
         5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
         5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
         5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
         5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
         5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
         5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
         5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
         5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
         5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
         5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
         5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
         5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
         5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
         5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
         5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
      endcase
      if (k && x == 5'd28) c6 = 6'b001111;
      bal6 = ($countones(c6) == 3);
      // Table holds RD- codes; unbalanced codes and D.07 are inverted at RD+.
      if (dispin && (!bal6 || x == 5'd7)) c6 = ~c6;
      rd6 = bal6 ? dispin : !dispin;
      a7 = k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20))
              || ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
      case (y)
         3'd0: c4 = 4'b1011;
         3'd1: c4 = k ? 4'b0110 : 4'b1001;
         3'd2: c4 = k ? 4'b1010 : 4'b0101;
         3'd3: c4 = 4'b1100;
         3'd4: c4 = 4'b1101;
         3'd5: c4 = k ? 4'b0101 : 4'b1010;
         3'd6: c4 = k ? 4'b1001 : 4'b0110;
         3'd7: c4 = a7 ? 4'b0111 : 4'b1110;
      endcase
      bal4  = ($countones(c4) == 2);
      flip4 = !bal4 || y == 3'd3 || (k && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6));
      if (rd6 && flip4) c4 = ~c4;
      rd4 = bal4 ? rd6 : !rd6;
      for (int i = 0; i < 6; i++) out[i] = c6[5-i];
      for (int i = 0; i < 4; i++) out[6+i] = c4[3-i];
      return {rd4, out};
   endfunction

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             rd_q, rd_d;
   logic             buf_valid_q, buf_valid_d;
   logic [8:0]       buf_data_q, buf_data_d;
   logic             sob_q, sob_d;
   logic             sent_q, sent_d;

   logic             load;
   logic             ready;
   logic             accept;
   logic [8:0]       sel_sym;
   logic [10:0]      enc;

   always_comb begin
      load    = (bit_cnt_q == 4'(WIDTH - 1));
      ready   = !buf_valid_q && rst_i;
      accept  = bus.valid && ready;
      sel_sym = buf_valid_q ? buf_data_q : IDLE_SYM;
      enc     = encode_8b10b(sel_sym, rd_q);

      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      rd_d        = rd_q;
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      sob_d       = 1'b0;
      sent_d      = 1'b0;

      if (load) begin
         shift_d     = enc[WIDTH-1:0];
         rd_d        = enc[10];
         bit_cnt_d   = 4'd0;
         sob_d       = 1'b1;
         sent_d      = buf_valid_q;
         buf_valid_d = 1'b0;
      end else begin
         shift_d   = {shift_q[WIDTH-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q + 4'd1;
      end

      // A byte accepted in a load cycle is held for the following symbol.
      if (accept) begin
         buf_valid_d = 1'b1;
         buf_data_d  = {bus.k, bus.data};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         shift_q     <= '0;
         bit_cnt_q   <= 4'(WIDTH - 1);
         rd_q        <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         sob_q       <= 1'b0;
         sent_q      <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rd_q        <= rd_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
         sob_q       <= sob_d;
         sent_q      <= sent_d;
      end
   end

   assign bus.ready    = ready;
   assign serialdata_o = shift_q[WIDTH-1];
   assign sob_o        = sob_q;
   assign data_sent_o  = sent_q;
   assign disp_o       = rd_q;

endmodule

// File: tb/tb_serializer_8b10b.sv
// Directed bench for serializer_8b10b: table of hand-encoded bytes plus
// reset, back-to-back, load-cycle accept and mid-symbol reset sequences.
module tb_serializer_8b10b;

   logic clk_i = 1'b0;
   logic rst_i;
   logic serialdata_o, sob_o, data_sent_o, disp_o;

   serializer_8b10b_if bif();

   serializer_8b10b dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .bus          (bif),
      .serialdata_o (serialdata_o),
      .sob_o        (sob_o),
      .data_sent_o  (data_sent_o),
      .disp_o       (disp_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       k;
      logic [7:0] d;
      logic [9:0] sym_n;
      logic       rd_n;
      logic [9:0] sym_p;
      logic       rd_p;
   } vec_t;

   typedef struct {
      logic [9:0] sym;
      logic       sent;
      logic       disp;
   } obs_t;

   vec_t vecs[6];
   vec_t cur_vec;
   vec_t expq[$];
   obs_t hist[$];
   int   acc_cyc[$];

   int   total, bad, cyc, pending, last_acc_cyc;
   logic rd_model;
   int   mon_cnt;
   logic mon_started;
   logic [9:0] mon_sh;
   logic mon_sent, mon_disp;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one clock; sample on the falling edge and run the symbol monitor.
   task automatic tick();
      logic acc;
      vec_t e;
      acc = (bif.valid === 1'b1) && (bif.ready === 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      if (acc) begin
         pending++;
         expq.push_back(cur_vec);
         acc_cyc.push_back(cyc);
         last_acc_cyc = cyc;
      end
      cyc++;
      if (!rst_i) begin
         mon_started = 1'b0;
         mon_cnt     = 0;
         pending     = 0;
         rd_model    = 1'b0;
      end else begin
         if (mon_started) check("sob_period", sob_o, mon_cnt == 10);
         if (sob_o) begin
            mon_started = 1'b1;
            mon_cnt     = 1;
            mon_sh      = {9'b0, serialdata_o};
            mon_sent    = data_sent_o;
            mon_disp    = disp_o;
            if (data_sent_o && pending > 0) pending--;
         end else if (mon_started) begin
            mon_sh = {mon_sh[8:0], serialdata_o};
            mon_cnt++;
         end
         if (mon_started && mon_cnt == 10) begin
            hist.push_back('{mon_sh, mon_sent, mon_disp});
            if (mon_sent) begin
               check("exp_queue_nonempty", expq.size() > 0, 1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  check("data_sym", mon_sh, rd_model ? e.sym_p : e.sym_n);
                  check("data_disp", mon_disp, rd_model ? e.rd_p : e.rd_n);
                  rd_model = rd_model ? e.rd_p : e.rd_n;
               end
            end else begin
               check("idle_sym", mon_sh, rd_model ? 10'h283 : 10'h17C);
               check("idle_disp", mon_disp, !rd_model);
               rd_model = !rd_model;
            end
         end
         if (pending > 0) check("ready_while_full", bif.ready, 0);
      end
   endtask

   task automatic wait_sob(int max);
      int b = 0;
      do begin tick(); b++; end while (!sob_o && b < max);
      check("wait_sob", sob_o, 1);
   endtask

   task automatic wait_data_sob(int max);
      int b = 0;
      do begin tick(); b++; end while (!(sob_o && data_sent_o) && b < max);
      check("wait_data_sob", sob_o && data_sent_o, 1);
   endtask

   task automatic wait_hist(int n, int max);
      int b = 0;
      while (hist.size() < n && b < max) begin tick(); b++; end
      check("wait_hist", hist.size() >= n, 1);
   endtask

   task automatic present(vec_t v);
      cur_vec   = v;
      bif.k     = v.k;
      bif.data  = v.d;
      bif.valid = 1'b1;
   endtask

   initial begin
      int base, n0;
      logic [9:0] exp_a;
      logic [9:0] idle_exp [3];
      logic       idle_rd  [3];

      total = 0; bad = 0; cyc = 0; pending = 0; last_acc_cyc = 0;
      rd_model = 1'b0; mon_cnt = 0; mon_started = 1'b0; mon_sh = '0;
      mon_sent = 1'b0; mon_disp = 1'b0;
      rst_i = 1'b0; bif.valid = 1'b0; bif.k = 1'b0; bif.data = 8'h00;

      vecs[0] = '{1'b0, 8'hB5, 10'h155, 1'b0, 10'h155, 1'b1};  // D21.5
      vecs[1] = '{1'b1, 8'hBC, 10'h17C, 1'b1, 10'h283, 1'b0};  // K28.5
      vecs[2] = '{1'b0, 8'h00, 10'h0B9, 1'b0, 10'h346, 1'b1};  // D0.0
      vecs[3] = '{1'b0, 8'h4A, 10'h2AA, 1'b0, 10'h2AA, 1'b1};  // D10.2
      vecs[4] = '{1'b0, 8'h27, 10'h247, 1'b0, 10'h278, 1'b1};  // D7.1
      vecs[5] = '{1'b0, 8'hF1, 10'h3B1, 1'b1, 10'h231, 1'b0};  // D17.7
      cur_vec = vecs[0];
      idle_exp[0] = 10'h17C; idle_rd[0] = 1'b1;
      idle_exp[1] = 10'h283; idle_rd[1] = 1'b0;
      idle_exp[2] = 10'h17C; idle_rd[2] = 1'b1;

      // Reset, then free-running idles
      repeat (3) begin
         tick();
         check("rst_serial", serialdata_o, 0);
         check("rst_sob", sob_o, 0);
         check("rst_ready", bif.ready, 0);
         check("rst_sent", data_sent_o, 0);
         check("rst_disp", disp_o, 0);
      end
      rst_i = 1'b1;
      #1;
      check("release_ready", bif.ready, 1);
      check("release_sob", sob_o, 0);
      tick();
      check("first_sob", sob_o, 1);
      check("first_bit", serialdata_o, 0);
      wait_hist(3, 40);
      for (int i = 0; i < 3; i++) begin
         if (hist.size() > i) begin
            check("init_idle_sym", hist[i].sym, idle_exp[i]);
            check("init_idle_disp", hist[i].disp, idle_rd[i]);
            check("init_idle_sent", hist[i].sent, 0);
         end
      end

      // Table-driven single bytes, presented two cycles after a load
      for (int i = 0; i < 6; i++) begin
         wait_sob(30);
         tick();
         base = hist.size();
         present(vecs[i]);
         check("vec_ready_free", bif.ready, 1);
         tick();
         bif.valid = 1'b0;
         wait_hist(base + 2, 30);
         if (hist.size() >= base + 2) begin
            check("vec_prev_is_idle", hist[base].sent, 0);
            check("vec_sent_flag", hist[base+1].sent, 1);
         end
      end

      // Back-to-back bytes with valid held high
      wait_sob(30);
      tick();
      base = hist.size();
      n0 = acc_cyc.size();
      present(vecs[0]);
      for (int b = 0; b < 50 && acc_cyc.size() < n0 + 3; b++) tick();
      bif.valid = 1'b0;
      check("b2b_accepts", acc_cyc.size() - n0, 3);
      if (acc_cyc.size() >= n0 + 3)
         check("b2b_accept_spacing", acc_cyc[n0+2] - acc_cyc[n0+1], 10);
      wait_hist(base + 4, 50);
      if (hist.size() >= base + 4)
         for (int i = 1; i < 4; i++) check("b2b_no_idle_gap", hist[base+i].sent, 1);

      // Accept in a load cycle: one idle first, worst-case latency
      wait_sob(30);
      repeat (9) tick();
      present(vecs[3]);
      check("loadacc_ready", bif.ready, 1);
      tick();
      bif.valid = 1'b0;
      check("loadacc_idle_sob", sob_o, 1);
      check("loadacc_idle_sent", data_sent_o, 0);
      wait_data_sob(15);
      check("latency_worst", cyc - last_acc_cyc, 11);

      // Accept one cycle before a load: best-case latency
      wait_sob(30);
      repeat (8) tick();
      present(vecs[5]);
      tick();
      bif.valid = 1'b0;
      tick();
      check("latency_best_sob", sob_o && data_sent_o, 1);
      check("latency_best", cyc - last_acc_cyc, 2);

      // Reset at bit 4 of a data symbol with a second byte buffered
      wait_sob(30);
      tick();
      present(vecs[2]);
      tick();
      bif.valid = 1'b0;
      wait_data_sob(15);
      exp_a = rd_model ? vecs[2].sym_p : vecs[2].sym_n;
      present(vecs[4]);
      check("mid_ready_free", bif.ready, 1);
      tick();
      bif.valid = 1'b0;
      repeat (4) tick();
      check("mid_bit4", serialdata_o, exp_a[4]);
      rst_i = 1'b0;
      expq.delete();
      tick();
      check("mid_rst_ready", bif.ready, 0);
      check("mid_rst_serial", serialdata_o, 0);
      check("mid_rst_disp", disp_o, 0);
      tick();
      rst_i = 1'b1;
      base = hist.size();
      tick();
      check("mid_first_sob", sob_o, 1);
      wait_hist(base + 3, 40);
      if (hist.size() >= base + 3) begin
         check("mid_first_sym", hist[base].sym, 10'h17C);
         check("mid_first_disp", hist[base].disp, 1);
         for (int i = 0; i < 3; i++) check("mid_buffer_dropped", hist[base+i].sent, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serializer_8b10b.md
# serializer_8b10b

Transmit-side 8b/10b serializer for the single-bit serial link. Accepts 8-bit data or control bytes over a valid/ready handshake and holds them in a one-entry buffer. Each byte is encoded with the team's combinational `encode_8b10b`, which this block drives with the running disparity. The 10-bit symbol is then shifted out MSB first, one bit per clock, into the link consumed by the `deserializer` block. With no data pending, the block transmits K28.5 comma idles so the receiver can keep symbol alignment.

## Interface
- `WIDTH`, 10: symbol width in bits; only 10 is supported.
- `IDLE_SYM`, 9'h1BC: `{k, byte}` sent when the buffer is empty (K28.5).
- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `data_i` in 8: byte to transmit.
- `k_i` in 1: 1 means `data_i` is a control (K) character.
- `valid_i` in 1: `data_i`/`k_i` are valid.
- `ready_o` out 1: buffer can accept; a transfer occurs when `valid_i && ready_o`.
- `serialdata_o` out 1: serial bit stream, symbol bit 9 first.
- `sob_o` out 1: high during the cycle that carries bit 9 of each symbol.
- `data_sent_o` out 1: high for that same cycle when the symbol came from the buffer rather than being an idle.
- `disp_o` out 1: current running disparity (0 = RD−, 1 = RD+).

## Operation
- Registers and their reset values (applied when `rst_i` = 0 at a clock edge):
  - `shift_q[9:0]` = 0
  - `bit_cnt[3:0]` = 9
  - `rd_q` = 0
  - `buf_valid` = 0
  - `buf_data[8:0]` = 0
  - `sob_q` = 0
  - `sent_q` = 0
- Outputs during and immediately after reset: `serialdata_o` = 0, `sob_o` = 0, `data_sent_o` = 0, `disp_o` = 0.
- `ready_o` = `!buf_valid && rst_i`, so it is low while reset is asserted.
- Accept: when `valid_i && ready_o`, `buf_data <= {k_i, data_i}` and `buf_valid <= 1`. Because `ready_o` is low whenever the buffer is full, a full buffer is never overwritten.
- Load cycle is any cycle with `bit_cnt` == 9:
  - Selected symbol: `buf_data` if `buf_valid`, otherwise `IDLE_SYM`. Selection uses the registered `buf_valid`, so a byte accepted during a load cycle waits for the next symbol.
  - Encoder inputs: selected symbol, `dispin = rd_q`.
  - `shift_q <=` encoder `dataout`; `rd_q <=` encoder `dispout`; `bit_cnt <= 0`; `sob_q <= 1`; `sent_q <= buf_valid`; `buf_valid <= 0`.
- Non-load cycle: `shift_q <= {shift_q[8:0], 1'b0}`; `bit_cnt <= bit_cnt + 1`; `sob_q <= 0`; `sent_q <= 0`.
- Output mapping: `serialdata_o` = `shift_q[9]`, `sob_o` = `sob_q`, `data_sent_o` = `sent_q`, `disp_o` = `rd_q`.
- `bit_cnt` cycles 0 through 9 and never exceeds 9. It wraps from 9 to 0 only in the load cycle.
- An illegal K code is passed to the encoder unchanged. Its output is transmitted as produced, and the block flags nothing.
- Running disparity updates on every symbol, idles included.
- Reset asserted mid-symbol: the partial symbol is abandoned and any buffered byte is dropped. The first symbol after reset is encoded from RD−.

## Timing
- Symbol period: exactly 10 cycles. The stream is continuous, with no gap bits between symbols.
- First post-reset cycle (`rst_i` high) is a load cycle. Bit 9 of the first symbol appears on `serialdata_o` one cycle later, with `sob_o` = 1.
- Latency, from an accept in cycle t to the first bit: the first bit appears in cycle L+1, where L is the first load cycle ≥ t+1.
  - Best case: 2 cycles.
  - Worst case: 11 cycles.
- `ready_o` stays low from the cycle after the accept until the cycle after the byte is loaded.
- Sustained throughput: one byte per 10 cycles.
- `disp_o` changes in the same cycle `sob_o` rises. It reflects the disparity after the symbol currently on the line.

## Test plan
- Reset then idle: hold `rst_i` low 3 cycles, then release with `valid_i` = 0.
  - During reset: `serialdata_o` = 0, `sob_o` = 0, `ready_o` = 0.
  - After release: symbols 0x17C, 0x283, 0x17C alternate, `sob_o` pulses every 10 cycles, and `disp_o` toggles 1, 0, 1.
- Single data byte: present D21.5 (`data_i` = 0xB5, `k_i` = 0) two cycles after a load.
  - Next symbol after the current one is 0x155, with `data_sent_o` = 1.
  - `disp_o` is unchanged, since the symbol is neutral.
- Back-to-back bytes: `valid_i` held high with 0xB5, 0xB5, 0xB5.
  - Each byte is accepted once per 10 cycles.
  - Output is 0x155 ×3 with no idle between, and `ready_o` is never high while the buffer is full.
- Accept in load cycle: assert `valid_i` exactly in a `bit_cnt` == 9 cycle.
  - One idle symbol is sent first; the byte goes out in the following symbol.
- Reset mid-symbol: assert reset at bit 4 of a data symbol while another byte is buffered.
  - Buffer is dropped; after release the first symbol is 0x17C (RD−).
- Loopback: drive `serialdata_o` into `deserializer`, sending K28.5 then random bytes.
  - Decoded bytes match the input, with `code_err_o` = 0 and `disp_err_o` = 0.
